aes_round_key_sequencer: RTL and testbench
==========================================

Name: aes_round_key_sequencer

Overview:
Controller that steps the 1-to-11 round-key demultiplexer in the cipher unit through key slots 0..10. It accepts a start command, then takes one round key per valid/ready transfer from key expansion. For each transfer it drives the slot select code and the data-enable strobe. It flags the first and last rounds for the cipher datapath and pulses done when all slots are filled.

Parameters:
NUM_ROUNDS, 10, number of cipher rounds; key slots = NUM_ROUNDS+1 (11).
SEL_W, 4, width of the slot select code; must satisfy 2**SEL_W >= NUM_ROUNDS+1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  begin a key-load sequence; honoured only in IDLE.
abort  input  1  cancel the sequence; returns to IDLE.
rk_valid  input  1  key expansion presents a round key this cycle.
rk_ready  output  1  sequencer accepts a round key this cycle.
sel  output  SEL_W  demux slot select, binary slot index 0..NUM_ROUNDS.
wr_en  output  1  demux data-enable; high only on an accepted transfer.
first_rnd  output  1  current slot is 0 (initial AddRoundKey).
last_rnd  output  1  current slot is NUM_ROUNDS (final round, no MixColumns).
busy  output  1  sequence in progress.
done  output  1  one-cycle pulse after slot NUM_ROUNDS is written.

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising edge.
- Reset values: state=IDLE, sel=0, rk_ready=0, wr_en=0, first_rnd=0, last_rnd=0, busy=0, done=0.
- States:
  - IDLE: waiting for start.
  - LOAD: slot 0.
  - ROUND: slots 1..NUM_ROUNDS-1.
  - FINAL: slot NUM_ROUNDS.
  - DONE: one cycle.
- IDLE: start=1 and abort=0 -> LOAD next cycle with sel=0.
- rk_ready = 1 in LOAD/ROUND/FINAL when abort=0; otherwise 0. Decoded from state.
- Transfer = rk_valid & rk_ready. wr_en = transfer, combinational, so the demux sees enable and sel in the same cycle.
- On a transfer:
  - sel increments by 1.
  - LOAD -> ROUND; ROUND stays in ROUND until sel reaches NUM_ROUNDS-1, then -> FINAL.
  - FINAL -> DONE.
- With no transfer, state and sel hold; rk_valid may drop for any number of cycles.
- first_rnd = (state==LOAD). last_rnd = (state==FINAL). busy = state in {LOAD, ROUND, FINAL, DONE}.
- DONE: done=1 for exactly one cycle, sel holds at NUM_ROUNDS, then IDLE with sel cleared to 0. start is ignored in DONE.
- start is ignored while busy. No queuing: a start during busy is lost.
- abort=1 in any state:
  - wr_en and rk_ready are forced 0 that cycle.
  - Next state is IDLE, sel=0, and no done pulse.
  - abort takes priority over start and over a transfer in the same cycle.
- sel never takes codes NUM_ROUNDS+1..2**SEL_W-1. Demux outputs beyond slot NUM_ROUNDS are never enabled.
- Latency: start accepted at cycle t, rk_valid held high -> writes in cycles t+1..t+NUM_ROUNDS+1, done at t+NUM_ROUNDS+2, IDLE at t+NUM_ROUNDS+3.
- Reset mid-sequence: identical to abort, plus all outputs return to reset values next edge.

Decomposition:
- Shared package aes_ctrl_pkg:
  - state enum: IDLE, LOAD, ROUND, FINAL, DONE.
  - constants AES128_ROUNDS=10, AES128_KEY_SLOTS=11, SLOT_SEL_W=4.
- No sub-module. The 11-way demux is instantiated by the parent cipher unit, with sel driving its select code and wr_en driving its data input.

Test Plan:
1. Reset with rst_n=0 for 2 cycles, then start pulse and rk_valid=1 continuously -> wr_en high for 11 consecutive cycles with sel=0,1,...,10; first_rnd only at sel=0; last_rnd only at sel=10; done one cycle later; IDLE after.
2. start, then rk_valid toggling 1,0,0,1,... -> sel advances only on rk_valid&rk_ready; exactly 11 wr_en pulses; done after the 11th.
3. abort asserted with sel=5 and rk_valid=1 -> no wr_en that cycle; next cycle IDLE, sel=0, busy=0, no done pulse.
4. start re-asserted at sel=3 and again in DONE -> ignored; sequence completes normally; a fresh start in IDLE begins at sel=0.
5. rst_n=0 at sel=7 -> next edge all outputs at reset values; start after release runs a full 11-slot sequence.
6. start and abort both asserted in IDLE -> remains IDLE, rk_ready=0, busy=0.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared control definitions for the AES cipher unit.
//   state_t          : key-load sequencer states
//   AES128_ROUNDS    : cipher rounds for AES-128
//   AES128_KEY_SLOTS : round-key slots (rounds + initial AddRoundKey)
//   SLOT_SEL_W       : width of the slot select code
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    FINAL,
    DONE
  } state_t;

  localparam int unsigned AES128_ROUNDS    = 10;
  localparam int unsigned AES128_KEY_SLOTS = AES128_ROUNDS + 1;
  localparam int unsigned SLOT_SEL_W       = 4;

endpackage

// File: rtl/aes_round_key_sequencer.sv
// Steps the cipher unit's round-key demux through slots 0..NUM_ROUNDS,
// taking one round key per valid/ready transfer from key expansion.
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset
//   start     : begin a key-load sequence (honoured only in IDLE)
//   abort     : cancel the sequence, return to IDLE
//   rk_valid  : key expansion presents a round key
//   rk_ready  : sequencer accepts a round key this cycle
//   sel       : demux slot select, binary slot index 0..NUM_ROUNDS
//   wr_en     : demux data-enable, high only on an accepted transfer
//   first_rnd : current slot is 0
//   last_rnd  : current slot is NUM_ROUNDS
//   busy      : sequence in progress
//   done      : one-cycle pulse after the last slot is written
module aes_round_key_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES128_ROUNDS,
  parameter int unsigned SEL_W      = SLOT_SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             rk_valid,
  output logic             rk_ready,
  output logic [SEL_W-1:0] sel,
  output logic             wr_en,
  output logic             first_rnd,
  output logic             last_rnd,
  output logic             busy,
  output logic             done
);

  localparam logic [SEL_W-1:0] PRE_LAST_SEL = SEL_W'(NUM_ROUNDS - 1);

  state_t           state;
  state_t           state_nx;
  logic [SEL_W-1:0] sel_nx;
  logic             accepting;
  logic             xfer;

  // Ready is decoded from state but must drop in the same cycle as abort,
  // so it stays combinational rather than registered.
  assign accepting = (state == LOAD) || (state == ROUND) || (state == FINAL);
  assign rk_ready  = accepting && !abort;
  assign xfer      = rk_valid && rk_ready;
  assign wr_en     = xfer;

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    if (abort) begin
      state_nx = IDLE;
      sel_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nx = LOAD;
            sel_nx   = '0;
          end
        end
        LOAD: begin
          if (xfer) begin
            sel_nx   = sel + 1'b1;
            state_nx = (NUM_ROUNDS == 1) ? FINAL : ROUND;
          end
        end
        ROUND: begin
          if (xfer) begin
            sel_nx = sel + 1'b1;
            if (sel == PRE_LAST_SEL) begin
              state_nx = FINAL;
            end
          end
        end
        FINAL: begin
          // sel stays at NUM_ROUNDS through DONE so it never reaches
          // an unused demux code.
          if (xfer) begin
            state_nx = DONE;
          end
        end
        DONE: begin
          state_nx = IDLE;
          sel_nx   = '0;
        end
        default: begin
          state_nx = IDLE;
          sel_nx   = '0;
        end
      endcase
    end
  end

  // Status flags are registered from the next state so they line up
  // exactly with the state register without extra decode on the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      first_rnd <= 1'b0;
      last_rnd  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      sel       <= sel_nx;
      first_rnd <= (state_nx == LOAD);
      last_rnd  <= (state_nx == FINAL);
      busy      <= (state_nx != IDLE);
      done      <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_aes_round_key_sequencer.sv
module tb_aes_round_key_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       rk_valid;
  logic       rk_ready;
  logic [3:0] sel;
  logic       wr_en;
  logic       first_rnd;
  logic       last_rnd;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  aes_round_key_sequencer #(
    .NUM_ROUNDS(10),
    .SEL_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .rk_valid(rk_valid),
    .rk_ready(rk_ready),
    .sel(sel),
    .wr_en(wr_en),
    .first_rnd(first_rnd),
    .last_rnd(last_rnd),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout: {rk_ready, sel[3:0], wr_en, first_rnd, last_rnd, busy, done}
  typedef struct {
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       valid;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [9:0] ex(input logic rdy, input logic [3:0] s,
                                    input logic wr, input logic f, input logic l,
                                    input logic b, input logic d);
    return {rdy, s, wr, f, l, b, d};
  endfunction

  function automatic void add(input logic r, input logic st, input logic ab,
                              input logic v, input logic [9:0] e);
    vec_t t;
    t.rst_n = r; t.start = st; t.abort = ab; t.valid = v; t.exp = e;
    tbl.push_back(t);
  endfunction

  // Drive inputs on the falling edge, then settle before sampling.
  task automatic step(input logic r, input logic st, input logic ab, input logic v);
    @(negedge clk);
    rst_n = r; start = st; abort = ab; rk_valid = v;
    #1;
  endtask

  task automatic chk(input string name, input logic [9:0] e);
    logic [9:0] act;
    act = {rk_ready, sel, wr_en, first_rnd, last_rnd, busy, done};
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s got rdy/sel/wr/f/l/b/d=%b required %b", name, act, e);
    end
  endtask

  // One accepted transfer at slot s, rk_valid high.
  task automatic write_row(input string name, input int s, input logic st);
    step(1'b1, st, 1'b0, 1'b1);
    chk($sformatf("%s_sel%0d", name, s),
        ex(1'b1, 4'(s), 1'b1, s == 0, s == 10, 1'b1, 1'b0));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rk_valid = 1'b0;

    // Full sequence with rk_valid held high, then start+abort in IDLE.
    add(1, 1, 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
    add(1, 0, 0, 1, ex(1, 0, 1, 1, 0, 1, 0));
    for (int s = 1; s <= 9; s++) add(1, 0, 0, 1, ex(1, 4'(s), 1, 0, 0, 1, 0));
    add(1, 0, 0, 1, ex(1, 10, 1, 0, 1, 1, 0));
    add(1, 0, 0, 1, ex(0, 10, 0, 0, 0, 1, 1));
    add(1, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 1, 1, ex(0, 0, 0, 0, 0, 0, 0));
    add(1, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0));

    // Reset held for two edges.
    @(posedge clk);
    @(posedge clk);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset", ex(0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].start, tbl[i].abort, tbl[i].valid);
      chk($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // rk_valid pattern 1,0,0: writes at c=0,3,...,30.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("toggle_start", ex(0, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c <= 30; c++) begin
      int s;
      s = (c + 2) / 3;
      step(1'b1, 1'b0, 1'b0, (c % 3) == 0);
      chk($sformatf("toggle_c%0d", c),
          ex(1, 4'(s), (c % 3) == 0, s == 0, s == 10, 1, 0));
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("toggle_done", ex(0, 10, 0, 0, 0, 1, 1));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("toggle_idle", ex(0, 0, 0, 0, 0, 0, 0));

    // Abort at sel=5 with rk_valid high.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int s = 0; s <= 4; s++) write_row("abort", s, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("abort_cycle", ex(0, 5, 0, 0, 0, 1, 0));
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("abort_idle", ex(0, 0, 0, 0, 0, 0, 0));
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("abort_nodone", ex(0, 0, 0, 0, 0, 0, 0));

    // start while busy (sel=3) and in DONE is ignored.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int s = 0; s <= 10; s++) write_row("restart", s, s == 3);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("restart_done", ex(0, 10, 0, 0, 0, 1, 1));
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("restart_idle", ex(0, 0, 0, 0, 0, 0, 0));
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("fresh_start", ex(0, 0, 0, 0, 0, 0, 0));
    write_row("fresh", 0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("fresh_abort", ex(0, 1, 0, 0, 0, 1, 0));

    // Reset mid-sequence at sel=7, then a full run.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_start", ex(0, 0, 0, 0, 0, 0, 0));
    for (int s = 0; s <= 6; s++) write_row("rstmid", s, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_cycle", ex(1, 7, 1, 0, 0, 1, 0));
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_after", ex(0, 0, 0, 0, 0, 0, 0));
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int s = 0; s <= 10; s++) write_row("rerun", s, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("rerun_done", ex(0, 10, 0, 0, 0, 1, 1));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rerun_idle", ex(0, 0, 0, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
